regfile_dump_reader: RTL

- Sequential read-side agent for the pipeline register file.
- On a start pulse it walks a range of register addresses through one regfile read port (A1/RD1 or A2/RD2).
- It streams each {address, data} pair out over a valid/ready interface, for debug dump, context save and bench checking.
- It snoops the regfile write port (WriteReg/WD/WE) so every emitted word is coherent with writes that land during the dump.

---
 rtl/regfile_pkg.sv | 18 +
 rtl/regdump_snoop_mux.sv | 39 +++
 rtl/regfile_dump_reader.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/regfile_pkg.sv
// Purpose: shared widths, the hardwired-zero register index and the dump FSM state type.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package regfile_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int REG_DATA_W = 32;

    // Register index that reads as zero when the regfile hardwires it.
    localparam logic [REG_ADDR_W-1:0] ZERO_REG = '0;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        SEND  = 2'd2
    } dump_state_t;

endpackage

// File: rtl/regdump_snoop_mux.sv
// Purpose: selects the coherent value of one register: forced zero, snooped write data, or a base value.
// Latency: purely combinational.
// Backpressure: none; the caller decides when the selected value is captured.
//
// Ports:
//   addr      register being observed
//   base_data value to use when no snooped write hits addr (regfile read or held beat data)
//   wb_we/wb_addr/wb_data  snoop of the regfile write port
//   sel_data  coherent register value
module regdump_snoop_mux
    import regfile_pkg::*;
#(
    parameter int DATA_W         = REG_DATA_W,
    parameter int ADDR_W         = REG_ADDR_W,
    parameter bit ZERO_HARDWIRED = 1'b1
) (
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] base_data,
    input  logic              wb_we,
    input  logic [ADDR_W-1:0] wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    output logic [DATA_W-1:0] sel_data
);

    logic is_zero_reg;

    assign is_zero_reg = ZERO_HARDWIRED && (addr == ADDR_W'(ZERO_REG));

    // Zero-force wins over the bypass so a write to the hardwired register is never seen.
    always_comb begin
        sel_data = base_data;
        if (is_zero_reg) begin
            sel_data = '0;
        end else if (wb_we && (wb_addr == addr)) begin
            sel_data = wb_data;
        end
    end

endmodule

// File: rtl/regfile_dump_reader.sv
// Purpose: on start, walks registers first..last (wrapping) through one regfile read port and streams {addr,data} beats.
// Latency: one beat per 2 cycles with out_ready held high; done pulses 2*beats cycles after the start edge.
// Backpressure: out_ready low holds the beat stable (snooped writes to that register still refresh out_data).
//
// Ports:
//   clk, rst_n                 clock, synchronous active-low reset
//   start, first_addr, last_addr  dump request and inclusive address range (latched in IDLE)
//   rd_addr / rd_data          regfile read port (combinational read)
//   wb_we, wb_addr, wb_data    snoop of the regfile write port
//   out_valid/out_ready, out_addr, out_data  beat stream
//   busy, done                 dump in progress / one-cycle completion pulse
//   checksum                   XOR of all transferred data, only when REGDUMP_CHECKSUM_EN is defined
module regfile_dump_reader
    import regfile_pkg::*;
#(
    parameter int DATA_W         = REG_DATA_W,
    parameter int ADDR_W         = REG_ADDR_W,
    parameter bit ZERO_HARDWIRED = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] first_addr,
    input  logic [ADDR_W-1:0] last_addr,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] rd_data,
    input  logic              wb_we,
    input  logic [ADDR_W-1:0] wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W-1:0] out_addr,
    output logic [DATA_W-1:0] out_data,
    output logic              busy,
    output logic              done
`ifdef REGDUMP_CHECKSUM_EN
    ,
    output logic [DATA_W-1:0] checksum
`endif
);

    dump_state_t       state_q;
    dump_state_t       state_d;
    logic [ADDR_W-1:0] cur_q;
    logic [ADDR_W-1:0] last_q;
    logic [DATA_W-1:0] fetch_data;
    logic [DATA_W-1:0] hold_data;
    logic              xfer;
    logic              is_last;

    assign xfer    = out_valid && out_ready;
    assign is_last = (out_addr == last_q);

    // Capture path: fresh regfile read, bypassed by a write landing in the same cycle.
    regdump_snoop_mux #(
        .DATA_W         (DATA_W),
        .ADDR_W         (ADDR_W),
        .ZERO_HARDWIRED (ZERO_HARDWIRED)
    ) u_fetch_mux (
        .addr      (cur_q),
        .base_data (rd_data),
        .wb_we     (wb_we),
        .wb_addr   (wb_addr),
        .wb_data   (wb_data),
        .sel_data  (fetch_data)
    );

    // Hold path: the presented beat tracks writes to its register while stalled.
    regdump_snoop_mux #(
        .DATA_W         (DATA_W),
        .ADDR_W         (ADDR_W),
        .ZERO_HARDWIRED (ZERO_HARDWIRED)
    ) u_hold_mux (
        .addr      (out_addr),
        .base_data (out_data),
        .wb_we     (wb_we),
        .wb_addr   (wb_addr),
        .wb_data   (wb_data),
        .sel_data  (hold_data)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic. start outside IDLE is deliberately ignored.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = FETCH;
            FETCH:   state_d = SEND;
            SEND:    if (xfer) state_d = is_last ? IDLE : FETCH;
            default: state_d = IDLE;
        endcase
    end

    // Combinational outputs. busy drops in the done cycle because the FSM is back in IDLE.
    always_comb begin
        rd_addr = cur_q;
        busy    = (state_q != IDLE);
    end

    // Datapath registers: address walk, beat capture/hold and the done pulse.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cur_q     <= '0;
            last_q    <= '0;
            out_valid <= 1'b0;
            out_addr  <= '0;
            out_data  <= '0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        cur_q  <= first_addr;
                        last_q <= last_addr;
                    end
                end
                FETCH: begin
                    out_addr  <= cur_q;
                    out_data  <= fetch_data;
                    out_valid <= 1'b1;
                end
                SEND: begin
                    if (xfer) begin
                        out_valid <= 1'b0;
                        if (is_last) begin
                            done <= 1'b1;
                        end else begin
                            // Natural ADDR_W overflow gives the wrap from the top register to 0.
                            cur_q <= cur_q + ADDR_W'(1);
                        end
                    end else begin
                        out_data <= hold_data;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef REGDUMP_CHECKSUM_EN
    // Accumulates the value actually handed over, so a same-cycle write cannot leak in.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            checksum <= '0;
        end else if ((state_q == IDLE) && start) begin
            checksum <= '0;
        end else if ((state_q == SEND) && xfer) begin
            checksum <= checksum ^ out_data;
        end
    end
`endif

endmodule
